// File: rtl/ldpc_pkg.sv
// ldpc_pkg: shared constants and types for the LDPC datapath blocks.
//   LDPC_MAXZ   - maximum lifting size, also the datapath width
//   LDPC_TAG_W  - width of the opaque sideband tag carried with each beat
//   LDPC_Z_W    - width of a lifting-size field (holds 0..LDPC_MAXZ)
//   LDPC_SH_W   - width of a shift field (holds 0..LDPC_MAXZ-1)
//   beat_t      - one pipeline stage's contents: valid, data, Z, shift, tag
//   z_mask()    - mask with ones in bits [z-1:0]
package ldpc_pkg;

  localparam int LDPC_MAXZ  = 81;
  localparam int LDPC_TAG_W = 8;
  localparam int LDPC_Z_W   = $clog2(LDPC_MAXZ + 1);
  localparam int LDPC_SH_W  = $clog2(LDPC_MAXZ);

  typedef struct packed {
    logic                  valid;
    logic [LDPC_MAXZ-1:0]  data;
    logic [LDPC_Z_W-1:0]   z;
    logic [LDPC_SH_W-1:0]  shift;
    logic [LDPC_TAG_W-1:0] tag;
  } beat_t;

  // Shifting by z >= LDPC_MAXZ clears every bit, so z = LDPC_MAXZ gives all ones.
  function automatic logic [LDPC_MAXZ-1:0] z_mask(input logic [LDPC_Z_W-1:0] z);
    return ~({LDPC_MAXZ{1'b1}} << z);
  endfunction

endpackage

// File: rtl/unshift_stage.sv
// unshift_stage: combinational conditional left rotation within Z.
// When enabled, rotates the low Z bits left by (2^J mod Z):
//   o_data[k] = i_data[(k - r) mod Z], r = 2^J mod Z, for k < Z.
// Bits at and above Z are zero on the output. The caller guarantees that
// i_data is already zero above Z and that i_en is 0 whenever i_z is 0.
// Parameters: J - stage index (rotation amount 2^J)
// Ports:
//   i_data [LDPC_MAXZ-1:0] - block to rotate
//   i_z    [LDPC_Z_W-1:0]  - active lifting size
//   i_en                   - apply the rotation
//   o_data [LDPC_MAXZ-1:0] - rotated (or passed-through) block
module unshift_stage
  import ldpc_pkg::*;
#(
  parameter int J = 0
) (
  input  logic [LDPC_MAXZ-1:0] i_data,
  input  logic [LDPC_Z_W-1:0]  i_z,
  input  logic                 i_en,
  output logic [LDPC_MAXZ-1:0] o_data
);

  logic [LDPC_Z_W-1:0]  w_rot;
  logic [LDPC_MAXZ-1:0] w_rotated;

  always_comb begin
    w_rot = '0;
    if (i_z != '0) begin
      w_rot = LDPC_Z_W'(1 << J) % i_z;
    end
    // Low part moves up by r; the top r bits of the Z-wide field wrap to the
    // bottom. With r = 0 the right shift is by Z and contributes nothing.
    w_rotated = ((i_data << w_rot) | (i_data >> (i_z - w_rot))) & z_mask(i_z);
    o_data    = i_en ? w_rotated : i_data;
  end

endmodule

// File: rtl/pipelined_circular_unshifter.sv
// pipelined_circular_unshifter: undoes a right rotation within lifting size Z.
//   out_data[k] = in_data[(k - shift_val) mod Z] for k < Z, zero above Z.
// shift_val >= Z is treated as 0; z_in = 0 or z_in > MAXZ gives all zeros.
// The rotation is decomposed into $clog2(MAXZ) registered stages; stage j
// rotates by 2^j mod Z when bit j of the beat's shift is set. Z, shift and
// tag travel with the data so beats of different Z can follow back-to-back.
// Latency is $clog2(MAXZ) cycles, throughput one beat per cycle.
//
// Handshake: a beat moves on a port only in a cycle where valid and ready
// are both 1. valid is never withdrawn before the transfer and the payload is
// held stable while valid=1 and ready=0. The whole pipeline advances together
// whenever the last stage is empty or being drained, so in_ready is simply
// out_ready | ~out_valid; on a stall every stage freezes.
//
// Optional feature: define UNSHIFT_CHECK_EN to raise sticky err_o on an
// accepted beat with z_in = 0, z_in > MAXZ or shift_val >= z_in. Without it
// err_o is tied to 0; the data path behaves identically either way.
//
// Ports:
//   CLK, rst_n             - clock, synchronous active-low reset
//   in_valid/in_ready      - input handshake
//   in_data, z_in, shift_val, tag_in - input beat
//   out_valid/out_ready    - output handshake
//   out_data, tag_out      - output beat
//   err_o                  - sticky illegal-parameter flag
// The MAXZ and TAG_W parameters must match the ldpc_pkg constants.
module pipelined_circular_unshifter
  import ldpc_pkg::*;
#(
  parameter int MAXZ  = LDPC_MAXZ,
  parameter int TAG_W = LDPC_TAG_W
) (
  input  logic                       CLK,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [MAXZ-1:0]            in_data,
  input  logic [$clog2(MAXZ+1)-1:0]  z_in,
  input  logic [$clog2(MAXZ)-1:0]    shift_val,
  input  logic [TAG_W-1:0]           tag_in,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [MAXZ-1:0]            out_data,
  output logic [TAG_W-1:0]           tag_out,
  output logic                       err_o
);

  localparam int L   = $clog2(MAXZ);
  localparam int Z_W = $clog2(MAXZ + 1);
  localparam logic [Z_W-1:0] MAXZ_V = Z_W'(MAXZ);

  beat_t w_in_beat;
  beat_t w_stage_in [L];
  beat_t w_next     [L];
  beat_t r_pipe     [L];
  logic  w_adv;
  logic  w_z_legal;
  logic  w_shift_legal;

  // Sanitise the incoming beat once so later stages never see an illegal Z
  // or an out-of-range shift: illegal Z zeroes the data, s >= Z becomes 0.
  always_comb begin
    w_z_legal     = (z_in != '0) && (z_in <= MAXZ_V);
    w_shift_legal = w_z_legal && (Z_W'(shift_val) < z_in);
    w_in_beat       = '0;
    w_in_beat.valid = in_valid;
    w_in_beat.tag   = tag_in;
    if (w_z_legal) begin
      w_in_beat.data = in_data & z_mask(z_in);
      w_in_beat.z    = z_in;
    end
    if (w_shift_legal) begin
      w_in_beat.shift = shift_val;
    end
  end

  assign w_adv    = out_ready | ~out_valid;
  assign in_ready = w_adv;

  for (genvar j = 0; j < L; j++) begin : g_stage
    logic [LDPC_MAXZ-1:0] w_rot_data;

    if (j == 0) begin : g_first
      assign w_stage_in[j] = w_in_beat;
    end else begin : g_rest
      assign w_stage_in[j] = r_pipe[j-1];
    end

    unshift_stage #(
      .J (j)
    ) u_stage (
      .i_data (w_stage_in[j].data),
      .i_z    (w_stage_in[j].z),
      .i_en   (w_stage_in[j].shift[j]),
      .o_data (w_rot_data)
    );

    assign w_next[j] = {w_stage_in[j].valid, w_rot_data, w_stage_in[j].z,
                        w_stage_in[j].shift, w_stage_in[j].tag};
  end

  always_ff @(posedge CLK) begin
    if (!rst_n) begin
      for (int j = 0; j < L; j++) begin
        r_pipe[j] <= '0;
      end
    end else if (w_adv) begin
      for (int j = 0; j < L; j++) begin
        r_pipe[j] <= w_next[j];
      end
    end
  end

  assign out_valid = r_pipe[L-1].valid;
  assign out_data  = r_pipe[L-1].data;
  assign tag_out   = r_pipe[L-1].tag;

`ifdef UNSHIFT_CHECK_EN
  logic r_err;

  always_ff @(posedge CLK) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if (in_valid && in_ready && !w_shift_legal) begin
      r_err <= 1'b1;
    end
  end

  assign err_o = r_err;
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_pipelined_circular_unshifter.sv
// Bench for pipelined_circular_unshifter (MAXZ=81, TAG_W=8).
module tb_pipelined_circular_unshifter;

  localparam int MAXZ  = 81;
  localparam int TAG_W = 8;
  localparam int Z_W   = 7;
  localparam int SH_W  = 7;
  localparam int L     = 7;
  localparam int W     = TAG_W + MAXZ;
`ifdef UNSHIFT_CHECK_EN
  localparam logic CHK = 1'b1;
`else
  localparam logic CHK = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic CLK = 1'b0;
  logic rst_n = 1'b0;
  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // ---------------- DUT signals ----------------
  logic             in_valid;
  logic             in_ready;
  logic [MAXZ-1:0]  in_data;
  logic [Z_W-1:0]   z_in;
  logic [SH_W-1:0]  shift_val;
  logic [TAG_W-1:0] tag_in;
  logic             out_valid;
  logic             out_ready;
  logic [MAXZ-1:0]  out_data;
  logic [TAG_W-1:0] tag_out;
  logic             err_o;

  logic rdy_random = 1'b0;
  logic rdy_force  = 1'b0;
  logic rnd_ready  = 1'b1;

  always begin
    @(posedge CLK);
    #1;
    rnd_ready = ($urandom_range(0, 3) != 0);
  end

  assign out_ready = rdy_random ? rnd_ready : rdy_force;

  pipelined_circular_unshifter #(
    .MAXZ  (MAXZ),
    .TAG_W (TAG_W)
  ) dut (
    .CLK       (CLK),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .z_in      (z_in),
    .shift_val (shift_val),
    .tag_in    (tag_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .tag_out   (tag_out),
    .err_o     (err_o)
  );

  // ---------------- reference model ----------------
  // Left rotation within z; illegal z gives zero, s >= z acts as s = 0.
  function automatic logic [MAXZ-1:0] model_unshift(input logic [MAXZ-1:0] d, input int z, input int s);
    logic [MAXZ-1:0] r;
    int ss;
    r = '0;
    if (z < 1 || z > MAXZ) return r;
    ss = (s >= z) ? 0 : s;
    for (int k = 0; k < z; k++) r[k] = d[(k - ss + z) % z];
    return r;
  endfunction

  // The team's right-rotating shifter: out[k] = in[(k + s) mod z].
  function automatic logic [MAXZ-1:0] model_rotr(input logic [MAXZ-1:0] d, input int z, input int s);
    logic [MAXZ-1:0] r;
    r = '0;
    for (int k = 0; k < z; k++) r[k] = d[(k + s) % z];
    return r;
  endfunction

  function automatic logic [MAXZ-1:0] rand_data();
    logic [95:0] t;
    t = {$urandom(), $urandom(), $urandom()};
    return t[MAXZ-1:0];
  endfunction

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  logic [W-1:0] drv_exp;
  int tests = 0;
  int fails = 0;
  logic err_model = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  logic             prev_stall = 1'b0;
  logic [MAXZ-1:0]  prev_data  = '0;
  logic [TAG_W-1:0] prev_tag   = '0;

  always @(negedge CLK) begin : compare
    logic [W-1:0] e;
    if (!rst_n) begin
      exp_q.delete();
      err_model  = 1'b0;
      prev_stall = 1'b0;
    end else begin
      check("err_o", err_o, err_model);
      if (prev_stall) begin
        check("stall_hold_valid", out_valid, 1);
        check("stall_hold_data", out_data, prev_data);
        check("stall_hold_tag", tag_out, prev_tag);
      end
      if (out_valid && !out_ready) check("in_ready_when_stalled", in_ready, 0);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("out_valid_with_empty_queue", out_valid, 0);
        end else begin
          e = exp_q.pop_front();
          check("out_data", out_data, e[MAXZ-1:0]);
          check("tag_out", tag_out, e[W-1:MAXZ]);
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(drv_exp);
        if (CHK && (z_in == 0 || z_in > MAXZ || shift_val >= z_in)) err_model = 1'b1;
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_tag   = tag_out;
    end
  end

  // ---------------- driver tasks ----------------
  // Call just after a rising edge; returns 1 time unit after the accept edge.
  task automatic send(input logic [MAXZ-1:0] d, input int z, input int s,
                      input logic [TAG_W-1:0] t, input logic [MAXZ-1:0] e);
    int n;
    in_valid  = 1'b1;
    in_data   = d;
    z_in      = Z_W'(z);
    shift_val = SH_W'(s);
    tag_in    = t;
    drv_exp   = {t, e};
    n = 0;
    @(negedge CLK);
    while (!in_ready && n < 300) begin
      @(negedge CLK);
      n++;
    end
    if (!in_ready) check("send_accept_timeout", in_ready, 1);
    @(posedge CLK);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 1000) begin
      @(posedge CLK);
      n++;
    end
    check(name, exp_q.size(), 0);
    @(posedge CLK);
    #1;
  endtask

  task automatic latency_beat(input logic [MAXZ-1:0] d, input int z, input int s,
                              input logic [TAG_W-1:0] t, input logic [MAXZ-1:0] e);
    int lat;
    rdy_random = 1'b0;
    rdy_force  = 1'b1;
    send(d, z, s, t, e);
    lat = 1;
    @(negedge CLK);
    while (!out_valid && lat < 50) begin
      @(posedge CLK);
      lat++;
      @(negedge CLK);
    end
    check("latency", lat, L);
    drain("latency_drain");
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin : main
    logic [MAXZ-1:0] d;
    int s;
    int z;
    int c0;

    in_valid = 1'b0; in_data = '0; z_in = '0; shift_val = '0; tag_in = '0; drv_exp = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    rst_n = 1'b1;

    // Reset state, with out_ready low so in_ready must come from ~out_valid.
    @(negedge CLK);
    check("reset_out_valid", out_valid, 0);
    check("reset_out_data", out_data, 0);
    check("reset_tag_out", tag_out, 0);
    check("reset_in_ready", in_ready, 1);
    check("reset_err_o", err_o, 0);
    @(posedge CLK);
    #1;
    rdy_force = 1'b1;

    // Hand-computed values that pin the reference model.
    check("model_pin_z8_s3_01", model_unshift(81'h01, 8, 3), 81'h08);
    check("model_pin_z8_s3_80", model_unshift(81'h80, 8, 3), 81'h04);
    check("model_pin_z8_s9", model_unshift(81'hF0F, 8, 9), 81'h0F);
    check("model_pin_z24_s5", model_unshift(81'h1, 24, 5), 81'h20);
    check("model_pin_z0", model_unshift(81'hFF, 0, 0), 81'h0);
    check("model_pin_rotr", model_rotr(81'h08, 8, 3), 81'h01);

    // Directed beats with literal expectations and exact latency.
    latency_beat(81'h01, 8, 3, 8'hA1, 81'h08);
    latency_beat(81'h80, 8, 3, 8'hA2, 81'h04);

    // Round trip: right shifter then this block must restore the original.
    rdy_random = 1'b1;
    for (int i = 0; i < 200; i++) begin
      d = rand_data();
      s = $urandom_range(0, 80);
      send(model_rotr(d, 81, s), 81, s, TAG_W'(i), d);
    end
    drain("roundtrip_drain");

    // Fill the pipeline with out_ready low, hold the stall, then release.
    rdy_random = 1'b0;
    rdy_force  = 1'b0;
    c0 = cyc;
    for (int i = 0; i < L; i++) begin
      d = rand_data();
      s = $urandom_range(0, 80);
      send(d, 81, s, TAG_W'(8'h40 + i), model_unshift(d, 81, s));
    end
    check("fill_one_beat_per_cycle", cyc - c0, L);
    d = rand_data();
    fork
      send(d, 24, 7, 8'h58, model_unshift(d, 24, 7));
      begin
        repeat (3) begin
          @(negedge CLK);
          check("stall_in_ready", in_ready, 0);
          check("stall_out_valid", out_valid, 1);
          @(posedge CLK);
        end
        #1;
        rdy_force = 1'b1;
      end
    join
    drain("stall_drain");

    // Interleaved lifting sizes, back-to-back, with garbage in the upper bits.
    rdy_random = 1'b1;
    for (int i = 0; i < 12; i++) begin
      d = rand_data();
      z = (i % 2 == 0) ? 24 : 81;
      s = (i % 2 == 0) ? 5 : 80;
      send(d, z, s, TAG_W'(8'h60 + i), model_unshift(d, z, s));
    end
    drain("interleave_drain");

    // Illegal shift / Z values.
    rdy_random = 1'b0;
    rdy_force  = 1'b1;
    check("err_before_illegal", err_o, 0);
    d = rand_data();
    send(d, 8, 9, 8'h70, d & 81'hFF);
    d = rand_data();
    send(d, 0, 3, 8'h71, 81'h0);
    d = rand_data();
    send(d, 100, 2, 8'h72, 81'h0);
    d = rand_data();
    send(d, 81, 81, 8'h73, d);
    drain("illegal_drain");
    check("err_after_illegal", err_o, CHK);
    d = rand_data();
    send(d, 16, 3, 8'h74, model_unshift(d, 16, 3));
    drain("legal_after_illegal_drain");
    check("err_sticky", err_o, CHK);

    // Reset with 4 beats in flight: nothing may come out afterwards.
    for (int i = 0; i < 4; i++) begin
      d = rand_data();
      send(d, 81, i + 1, TAG_W'(8'h80 + i), model_unshift(d, 81, i + 1));
    end
    rst_n = 1'b0;
    @(posedge CLK);
    #1;
    rst_n = 1'b1;
    @(negedge CLK);
    check("midreset_out_valid", out_valid, 0);
    check("midreset_err_o", err_o, 0);
    check("midreset_in_ready", in_ready, 1);
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      check("no_stale_beat", out_valid, 0);
    end
    @(posedge CLK);
    #1;

    // Normal traffic after reset.
    rdy_random = 1'b1;
    for (int i = 0; i < 10; i++) begin
      z = $urandom_range(1, 81);
      s = $urandom_range(0, z - 1);
      d = rand_data();
      send(d, z, s, TAG_W'(8'h90 + i), model_unshift(d, z, s));
    end
    drain("post_reset_drain");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
